// File: rtl/key_pkg.sv
// Shared key-FSM state type and key index constants for the direction-key conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  localparam int unsigned KEY_UP    = 3;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 0;

endpackage

// File: rtl/dir_key_conditioner_if.sv
// Raw key / game-over inputs and move-pulse / held-level outputs of dir_key_conditioner.
interface dir_key_conditioner_if;

  logic       I_key_up;
  logic       I_key_down;
  logic       I_key_left;
  logic       I_key_right;
  logic       I_gameover;
  logic       O_up;
  logic       O_down;
  logic       O_left;
  logic       O_right;
  logic [3:0] O_held;

  modport master (
    output I_key_up, I_key_down, I_key_left, I_key_right, I_gameover,
    input  O_up, O_down, O_left, O_right, O_held
  );

  modport slave (
    input  I_key_up, I_key_down, I_key_left, I_key_right, I_gameover,
    output O_up, O_down, O_left, O_right, O_held
  );

endinterface

// File: rtl/key_debounce.sv
// Single key channel: 2-FF synchronizer, debounce FSM, registered request pulse and held level.
// Optional auto-repeat while held is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 15_000_000
`endif
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_key,
  output logic O_req,
  output logic O_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          key_meta;
  logic          key_s;
  key_state_t    state;
  key_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic          press_nxt;
  logic          req_nxt;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= I_key;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // With a 1-cycle debounce the first stable sample already completes the wait.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    cnt_inc   = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        if (key_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc >= CW'(DEBOUNCE_CYCLES)) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CW'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_inc >= CW'(DEBOUNCE_CYCLES)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX + 1);

  logic [RW-1:0] rpt;
  logic [RW-1:0] rpt_nxt;
  logic          rpt_periodic;
  logic          rpt_periodic_nxt;
  logic          rpt_fire;

  // rpt_periodic selects the shorter period once the initial delay has elapsed.
  always_comb begin
    rpt_nxt          = '0;
    rpt_periodic_nxt = 1'b0;
    rpt_fire         = 1'b0;
    if (state == PRESSED && state_nxt == PRESSED) begin
      rpt_nxt          = rpt + RW'(1);
      rpt_periodic_nxt = rpt_periodic;
      if (rpt_nxt >= (rpt_periodic ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        rpt_fire         = 1'b1;
        rpt_nxt          = '0;
        rpt_periodic_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rpt          <= '0;
      rpt_periodic <= 1'b0;
    end else begin
      rpt          <= rpt_nxt;
      rpt_periodic <= rpt_periodic_nxt;
    end
  end

  assign req_nxt = press_nxt | rpt_fire;
`else
  assign req_nxt = press_nxt;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_req <= 1'b0;
    end else begin
      O_req <= req_nxt;
    end
  end

  assign O_held = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/dir_key_conditioner.sv
// Four debounced direction keys, fixed-priority one-hot move pulses (up > down > left > right), game-over gating.
// KEY_AUTOREPEAT_EN adds auto-repeat pulses while a key stays held.
module dir_key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 15_000_000
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  dir_key_conditioner_if.slave  key_if
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("dir_key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [3:0] raw;
  logic [3:0] req;
  logic [3:0] held;
  logic [3:0] grant;
  logic [3:0] pulse_q;
  logic [3:0] held_q;

  assign raw[KEY_UP]    = key_if.I_key_up;
  assign raw[KEY_DOWN]  = key_if.I_key_down;
  assign raw[KEY_LEFT]  = key_if.I_key_left;
  assign raw[KEY_RIGHT] = key_if.I_key_right;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_key (
      .I_clk  (I_clk),
      .I_rst  (I_rst),
      .I_key  (raw[k]),
      .O_req  (req[k]),
      .O_held (held[k])
    );
  end

  // Losing requests are dropped, not queued.
  always_comb begin
    grant = '0;
    if (!key_if.I_gameover) begin
      if (req[KEY_UP])         grant[KEY_UP]    = 1'b1;
      else if (req[KEY_DOWN])  grant[KEY_DOWN]  = 1'b1;
      else if (req[KEY_LEFT])  grant[KEY_LEFT]  = 1'b1;
      else if (req[KEY_RIGHT]) grant[KEY_RIGHT] = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      pulse_q <= grant;
      held_q  <= held;
    end
  end

  assign key_if.O_up    = pulse_q[KEY_UP];
  assign key_if.O_down  = pulse_q[KEY_DOWN];
  assign key_if.O_left  = pulse_q[KEY_LEFT];
  assign key_if.O_right = pulse_q[KEY_RIGHT];
  assign key_if.O_held  = held_q;

endmodule

// File: tb/tb_dir_key_conditioner.sv
// Self-checking bench for dir_key_conditioner: directed scenarios plus random key traffic
// checked every cycle against a behavioural model of debounce, priority and game-over rules.
module tb_dir_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = '0;
  logic       go  = 1'b0;

  always #5 clk = ~clk;

  dir_key_conditioner_if kif ();

  assign kif.I_key_up    = raw[3];
  assign kif.I_key_down  = raw[2];
  assign kif.I_key_left  = raw[1];
  assign kif.I_key_right = raw[0];
  assign kif.I_gameover  = go;

  dir_key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .I_clk  (clk),
    .I_rst  (rst),
    .key_if (kif)
  );

  logic [3:0] obs_pulse;
  assign obs_pulse = {kif.O_up, kif.O_down, kif.O_left, kif.O_right};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: raw levels reach the debouncer two edges late; a debounced level flips after DB
  // consecutive samples disagree with it; a 0->1 flip (or repeat time) is a request that
  // appears on the outputs one edge later, after priority and game-over gating.
  logic [3:0] d1 = '0, d2 = '0, deb = '0, pend = '0;
  logic [3:0] exp_pulse = '0, exp_held = '0;
  int run [4] = '{0, 0, 0, 0};
  int t   [4] = '{0, 0, 0, 0};

  task automatic model_edge(input logic [3:0] r, input logic g, input logic rs);
    if (rs) begin
      d1 = '0; d2 = '0; deb = '0; pend = '0;
      exp_pulse = '0; exp_held = '0;
      for (int k = 0; k < 4; k++) begin run[k] = 0; t[k] = 0; end
      return;
    end
    exp_pulse = '0;
    if (!g) begin
      for (int k = 3; k >= 0; k--) begin
        if (pend[k]) begin exp_pulse[k] = 1'b1; break; end
      end
    end
    exp_held = deb;
    for (int k = 0; k < 4; k++) begin
      logic s;
      logic was_pressed;
      s = d2[k]; d2[k] = d1[k]; d1[k] = r[k];
      pend[k] = 1'b0;
      was_pressed = deb[k] && run[k] == 0;
      if (s != deb[k]) begin
        run[k]++;
        if (run[k] == DB) begin
          deb[k] = s; run[k] = 0;
          if (s) begin pend[k] = 1'b1; t[k] = 0; end
        end
      end else begin
        run[k] = 0;
      end
`ifdef KEY_AUTOREPEAT_EN
      if (was_pressed && deb[k] && run[k] == 0) begin
        t[k]++;
        if (t[k] == RD || (t[k] > RD && (t[k] - RD) % RP == 0)) pend[k] = 1'b1;
      end else if (!(deb[k] && run[k] == 0)) begin
        t[k] = 0;
      end
`else
      if (was_pressed) t[k] = 0;
`endif
    end
  endtask

  task automatic step();
    logic [3:0] r;
    logic g, rs;
    r = raw; g = go; rs = rst;
    @(posedge clk);
    model_edge(r, g, rs);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw = '1; go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== 4'b0000 || kif.O_held !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset cyc %0d: pulses=%b held=%b, expected pulses=0000 held=0000", i, obs_pulse, kif.O_held);
      end
    end
    raw = '0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL reset_settle cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int cnt = 0;
    raw = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_up) begin cnt++; if (first < 0) first = i; end
    end
    n_checks++;
    if (first != DB + 2) begin n_fail++; $display("FAIL clean_press_latency: first O_up at %0d, expected %0d", first, DB + 2); end
`ifndef KEY_AUTOREPEAT_EN
    n_checks++;
    if (cnt != 1) begin n_fail++; $display("FAIL clean_press_count: %0d O_up pulses, expected 1", cnt); end
`endif
    n_checks++;
    if (kif.O_held !== 4'b1000) begin n_fail++; $display("FAIL clean_press_held: held=%b, expected 1000", kif.O_held); end
    raw = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL clean_release cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (i == DB + 1) begin
        n_checks++;
        if (kif.O_held !== 4'b1000) begin n_fail++; $display("FAIL release_hold cyc %0d: held=%b, expected 1000", i, kif.O_held); end
      end
      if (i == DB + 2) begin
        n_checks++;
        if (kif.O_held !== 4'b0000) begin n_fail++; $display("FAIL release_drop cyc %0d: held=%b, expected 0000", i, kif.O_held); end
      end
    end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int first = -1;
    for (int i = 0; i < 18; i++) begin
      raw = {3'b000, pat[i % 6]};
      step();
      n_checks++;
      if (kif.O_right !== 1'b0 || kif.O_held !== 4'b0000 || obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: pulses=%b held=%b, expected pulses=0000 held=0000", i, obs_pulse, kif.O_held);
      end
    end
    raw = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL bounce_stable cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_right && first < 0) first = i;
    end
    n_checks++;
    if (first != DB + 2) begin n_fail++; $display("FAIL bounce_latency: first O_right at %0d, expected %0d", first, DB + 2); end
    raw = '0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_simultaneous();
    int n_down = 0;
    int n_left = 0;
    raw = 4'b0110;
    for (int i = 0; i < 15; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL simultaneous cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_down) n_down++;
      if (kif.O_left) n_left++;
    end
    n_checks++;
    if (n_down != 1 || n_left != 0) begin
      n_fail++;
      $display("FAIL simultaneous_count: down=%0d left=%0d, expected down=1 left=0", n_down, n_left);
    end
    n_checks++;
    if (kif.O_held !== 4'b0110) begin n_fail++; $display("FAIL simultaneous_held: held=%b, expected 0110", kif.O_held); end
    raw = '0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_gameover();
    int n_left = 0;
    go = 1'b1; raw = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL gameover cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_left) n_left++;
    end
    n_checks++;
    if (n_left != 0 || kif.O_held[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL gameover_gate: left pulses=%0d held=%b, expected 0 pulses and held[1]=1", n_left, kif.O_held);
    end
    go = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL gameover_clear cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_left) n_left++;
    end
`ifndef KEY_AUTOREPEAT_EN
    n_checks++;
    if (n_left != 0) begin n_fail++; $display("FAIL gameover_no_late_pulse: left pulses=%0d, expected 0", n_left); end
`endif
    raw = '0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid_press();
    int first = -1;
    raw = 4'b1000;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== 4'b0000 || kif.O_held !== 4'b0000) begin
        n_fail++;
        $display("FAIL mid_reset cyc %0d: pulses=%b held=%b, expected pulses=0000 held=0000", i, obs_pulse, kif.O_held);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
      if (kif.O_up && first < 0) first = i;
    end
    n_checks++;
    if (first != DB + 2) begin n_fail++; $display("FAIL after_reset_latency: first O_up at %0d, expected %0d", first, DB + 2); end
    raw = '0;
    for (int i = 0; i < 10; i++) step();
  endtask

`ifdef KEY_AUTOREPEAT_EN
  task automatic test_autorepeat();
    raw = 4'b1000;
    for (int i = 0; i < 38; i++) begin
      logic want;
      step();
      want = (i == DB + 2) || (i >= DB + 2 + RD && (i - (DB + 2 + RD)) % RP == 0);
      n_checks++;
      if (kif.O_up !== want || obs_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL autorepeat cyc %0d: O_up=%b pulses=%b, expected O_up=%b pulses=%b", i, kif.O_up, obs_pulse, want, exp_pulse);
      end
    end
    raw = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (kif.O_up !== 1'b0 || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL autorepeat_release cyc %0d: O_up=%b held=%b, expected O_up=0 held=%b", i, kif.O_up, kif.O_held, exp_held);
      end
    end
  endtask
`endif

  task automatic test_random();
    int left = 0;
    for (int i = 0; i < 500; i++) begin
      if (left == 0) begin
        raw  = 4'($urandom_range(0, 15));
        go   = ($urandom_range(0, 5) == 0);
        left = $urandom_range(1, 9);
      end
      left--;
      rst = ($urandom_range(0, 39) == 0);
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL random cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
    end
    rst = 1'b0; raw = '0; go = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (obs_pulse !== exp_pulse || kif.O_held !== exp_held) begin
        n_fail++;
        $display("FAIL random_drain cyc %0d: pulses=%b held=%b, expected pulses=%b held=%b", i, obs_pulse, kif.O_held, exp_pulse, exp_held);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_gameover();
    test_reset_mid_press();
`ifdef KEY_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_key_conditioner.md
# dir_key_conditioner

Conditions the four raw direction push-buttons (up/down/left/right) into clean, single-cycle move requests for the direction driver. Per key it synchronizes, debounces and detects presses, then arbitrates so at most one direction pulse fires per clock. Its outputs drive the direction driver's I_up/I_down/I_left/I_right inputs directly. Presses are suppressed while the game is over.

## Interface
- DEBOUNCE_CYCLES, 2_000_000 — consecutive stable cycles required to accept a press or a release (20 ms at 100 MHz); minimum 1.
- REPEAT_DELAY, 50_000_000 — cycles a key must stay pressed before the first auto-repeat pulse (used only with the macro).
- REPEAT_PERIOD, 15_000_000 — cycles between subsequent auto-repeat pulses (used only with the macro).
- I_clk  input  1  system clock.
- I_rst  input  1  synchronous reset, active-high.
- I_key_up / I_key_down / I_key_left / I_key_right  input  1 each  raw asynchronous button levels, 1 = pressed.
- I_gameover  input  1  while high, no direction pulses are emitted.
- O_up / O_down / O_left / O_right  output  1 each  one-cycle move pulse, at most one high per cycle.
- O_held  output  4  debounced key levels {up, down, left, right}, bit 3 = up.

## Operation
- Each key has a 2-FF synchronizer producing level s.
- Each key has a per-key FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter sized by $clog2(DEBOUNCE_CYCLES+1).
  - IDLE: s=1 → PRESS_WAIT, counter = 1.
  - PRESS_WAIT: s=1 increments the counter. When the counter reaches DEBOUNCE_CYCLES, go to PRESSED and raise the press request. s=0 → IDLE, counter cleared.
  - PRESSED: s=0 → RELEASE_WAIT, counter = 1.
  - RELEASE_WAIT: s=0 increments the counter. When it reaches DEBOUNCE_CYCLES → IDLE. s=1 → PRESSED, counter cleared, no new request.
- O_held bit is 1 in PRESSED and RELEASE_WAIT.
- Arbitration:
  - Fixed priority up > down > left > right.
  - When several requests occur in the same cycle, only the winner pulses. Losers are dropped and are not queued; their FSMs still enter PRESSED.
- Gameover: when I_gameover=1, all requests are discarded. FSMs and O_held keep tracking normally.
- Outputs are registered.

## Timing
- Reset: all FSMs go to IDLE, counters and synchronizers clear. All O_* outputs are 0, O_held = 4'b0000.
- Press latency: raw key high and stable from before edge 0 → its O_ pulse is high for exactly one cycle after edge DEBOUNCE_CYCLES+2.
  - Edges 1–2 are synchronizer delay.
  - Edge DEBOUNCE_CYCLES+1 is where the FSM sets the request.
  - Edge DEBOUNCE_CYCLES+2 registers the output.
- O_held rises in the same cycle as the pulse and falls DEBOUNCE_CYCLES+2 cycles after a stable release.
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse and no O_held change.
- Reset asserted mid-wait aborts the wait immediately. A key still held after reset produces a fresh press after the full latency.
- A key held indefinitely produces exactly one pulse (macro off).

## Configuration
- KEY_AUTOREPEAT_EN defined:
  - In PRESSED, a repeat counter runs.
  - The first repeat request comes REPEAT_DELAY cycles after entry to PRESSED.
  - Further repeat requests come every REPEAT_PERIOD cycles after that.
  - The counter clears when the key leaves PRESSED.
  - Repeat requests pass through the same arbitration and gameover gating as presses.
- KEY_AUTOREPEAT_EN undefined: no repeat logic or counters are synthesized. REPEAT_* parameters are ignored.

## Structure
- Shared package key_pkg holds:
  - the key FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - key index constants KEY_UP=3, KEY_DOWN=2, KEY_LEFT=1, KEY_RIGHT=0.
- Sub-module key_debounce is a single-channel synchronizer + FSM + counters. It outputs a request pulse and a held level, and is instantiated 4×.
- The top level contains only the arbiter, gameover gate and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Clean press of up held 20 cycles → O_up high one cycle at edge 6; O_held=4'b1000 from then; no further pulse; after release, O_held=0 six cycles later.
- Bouncy right: high 2 cycles, low 1, high 2, low, repeated → no O_right and O_held stays 0. Then held stable → single O_right after 6 cycles of stability.
- down and left pressed on the same edge → only O_down pulses; O_held=4'b0110; no O_left pulse later while both are held.
- I_gameover=1 with left pressed → no O_left; O_held[1]=1. Then I_gameover=0 while still held → still no pulse.
- I_rst asserted at cycle 3 of a press and released while up is still held → O_up pulse exactly 6 cycles after reset deasserts.
- With KEY_AUTOREPEAT_EN, up held 40 cycles → pulses at press, press+10, press+15, press+20, and so on; none after release.
